// File: rtl/axi_pkg.sv
// Shared AXI3 encodings and FSM state type for the SRAM-backed AXI responder.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] BURST_RSVD  = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_DATA,
    S_WR_DATA,
    S_WR_RESP
  } state_t;

  // Only FIXED/INCR, lengths up to max_len and sizes up to 4 bytes are served.
  function automatic logic req_err(input logic [1:0] burst, input logic [7:0] len,
                                   input logic [2:0] size, input logic [7:0] max_len);
    return (burst inside {BURST_WRAP, BURST_RSVD}) || (len > max_len) || (size > 3'd2);
  endfunction

endpackage

// File: rtl/sram_sp_bw.sv
// Single-port synchronous RAM with per-byte write enables and one-cycle read latency.
module sram_sp_bw #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  rd_en,
  input  logic [DATA_W/8-1:0]   we,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     q
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  // One byte-wide array per lane keeps byte enables a plain per-lane write.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] q_lane;

    always_ff @(posedge clk) begin
      if (we[gi]) mem[addr] <= wdata[gi*8 +: 8];
      if (rd_en)  q_lane    <= mem[addr];
    end

    assign q[gi*8 +: 8] = q_lane;
  end

endmodule

// File: rtl/axi_sram_responder.sv
// AXI3 slave serving one read or write burst at a time from an on-chip SRAM,
// with round-robin arbitration between simultaneous read and write requests.
module axi_sram_responder
  import axi_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int MAX_LEN = 15
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int BA_W = ADDR_W + 2;

  state_t          state;
  logic            rr_pref;
  logic [3:0]      id_reg;
  logic [BA_W-1:0] addr_reg;
  logic [BA_W-1:0] addr_next;
  logic [7:0]      len_reg;
  logic [7:0]      beat_cnt;
  logic [2:0]      size_reg;
  logic [1:0]      burst_reg;
  logic            err_reg;

  logic            take_ar;
  logic            take_aw;
  logic            w_fire;
  logic            wr_en;
  logic [31:0]     ram_q;

  logic unused;
  assign unused = ^{araddr[31:BA_W], arlock, arcache, arprot,
                    awaddr[31:BA_W], awlock, awcache, awprot, wid};

  // rr_pref = 0 favours the write channel when both requests are pending.
  always_comb begin
    take_ar = 1'b0;
    take_aw = 1'b0;
    if (aresetn && state == S_IDLE) begin
      if (arvalid && awvalid) begin
        take_ar = rr_pref;
        take_aw = !rr_pref;
      end else begin
        take_ar = arvalid;
        take_aw = awvalid;
      end
    end
  end

  assign arready = take_ar;
  assign awready = take_aw;

  // Byte address wraps modulo the RAM size because only BA_W bits are kept.
  assign addr_next = (burst_reg == BURST_INCR) ? addr_reg + (BA_W'(1) << size_reg) : addr_reg;
  assign w_fire    = (state == S_WR_DATA) && wvalid && wready;
  assign wr_en     = w_fire && !err_reg;
  assign rdata     = (rvalid && !err_reg) ? ram_q : '0;

  sram_sp_bw #(
    .ADDR_W (ADDR_W),
    .DATA_W (32)
  ) u_ram (
    .clk   (aclk),
    .addr  (addr_reg[BA_W-1:2]),
    .rd_en (state == S_RD_REQ),
    .we    (wstrb & {4{wr_en}}),
    .wdata (wdata),
    .q     (ram_q)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= S_IDLE;
      rr_pref   <= 1'b0;
      id_reg    <= '0;
      addr_reg  <= '0;
      len_reg   <= '0;
      beat_cnt  <= '0;
      size_reg  <= '0;
      burst_reg <= '0;
      err_reg   <= 1'b0;
      wready    <= 1'b0;
      rvalid    <= 1'b0;
      rlast     <= 1'b0;
      rid       <= '0;
      rresp     <= '0;
      bvalid    <= 1'b0;
      bid       <= '0;
      bresp     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          beat_cnt <= '0;
          if (arvalid && awvalid) rr_pref <= !rr_pref;
          if (take_ar) begin
            id_reg    <= arid;
            addr_reg  <= araddr[BA_W-1:0];
            len_reg   <= arlen;
            size_reg  <= arsize;
            burst_reg <= arburst;
            err_reg   <= req_err(arburst, arlen, arsize, 8'(MAX_LEN));
            state     <= S_RD_REQ;
          end else if (take_aw) begin
            id_reg    <= awid;
            addr_reg  <= awaddr[BA_W-1:0];
            len_reg   <= awlen;
            size_reg  <= awsize;
            burst_reg <= awburst;
            err_reg   <= req_err(awburst, awlen, awsize, 8'(MAX_LEN));
            wready    <= 1'b1;
            state     <= S_WR_DATA;
          end
        end
        S_RD_REQ: begin
          rvalid <= 1'b1;
          rid    <= id_reg;
          rresp  <= err_reg ? RESP_SLVERR : RESP_OKAY;
          rlast  <= (beat_cnt == len_reg);
          state  <= S_RD_DATA;
        end
        S_RD_DATA: begin
          if (rready) begin
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            if (rlast) begin
              state <= S_IDLE;
            end else begin
              addr_reg <= addr_next;
              beat_cnt <= beat_cnt + 8'd1;
              state    <= S_RD_REQ;
            end
          end
        end
        S_WR_DATA: begin
          if (w_fire) begin
            addr_reg <= addr_next;
            beat_cnt <= beat_cnt + 8'd1;
            if (wlast) begin
              wready <= 1'b0;
              bvalid <= 1'b1;
              bid    <= id_reg;
              bresp  <= (err_reg || beat_cnt != len_reg) ? RESP_SLVERR : RESP_OKAY;
              state  <= S_WR_RESP;
            end else if (beat_cnt == len_reg) begin
              // Missing wlast: flag the error and swallow beats until wlast.
              err_reg <= 1'b1;
            end
          end
        end
        S_WR_RESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
